mau_accumulator: RTL and testbench
==================================

# mau_accumulator

Multi-lane pipelined ternary multiply-accumulate engine for the ternary polynomial multiplier. Each beat carries one coefficient and one ternary selector per lane; every lane adds, subtracts or ignores its coefficient into a private mod-q accumulator. After a programmed number of beats the accumulator vector is presented on a valid/ready output port. The block sits between the coefficient fetch logic and the result write-back in the mul_ternary accelerator.

## Interface
- PARAM_LOG_Q, 8, coefficient width in bits
- PARAM_Q, 251, modulus; requires PARAM_Q < 2**PARAM_LOG_Q
- LANES, 4, number of parallel accumulator lanes
- LEN_W, 10, width of the beat counter
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  begin a run; clears accumulators and latches len_i
- len_i  in  LEN_W  number of beats in the run
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  engine accepts a beat
- in_coef_i  in  LANES*PARAM_LOG_Q  lane i coefficient at [i*PARAM_LOG_Q +: PARAM_LOG_Q], value < PARAM_Q
- in_sel_i  in  2*LANES  lane i selector at [2i +: 2]
- out_valid_o  out  1  result vector valid
- out_ready_i  in  1  consumer accepts the result
- out_acc_o  out  LANES*PARAM_LOG_Q  accumulator vector, same lane packing as in_coef_i
- busy_o  out  1  high in ACC, DRAIN and DONE
- err_o  out  1  sticky: a reserved selector was seen during the current run

## Operation
- Selector codes: 00 hold, 01 add, 11 subtract, 10 reserved. Reserved code: the accumulator is unchanged and err_o is set.
- Add: the sum is computed in PARAM_LOG_Q+1 bits; PARAM_Q is subtracted if the sum >= PARAM_Q.
- Subtract: acc + PARAM_Q - coef is computed in PARAM_LOG_Q+1 bits, with the same conditional subtract. Coefficients >= PARAM_Q are out of contract.
- FSM states:
  - IDLE → ACC on start_i with len_i != 0.
  - IDLE → DONE on start_i with len_i == 0.
  - ACC → DRAIN when the last beat is accepted.
  - DRAIN → DONE after 1 cycle.
  - DONE → IDLE on out_valid_o && out_ready_i.
- start_i is also accepted in DONE in the same cycle as the output handshake; the block then goes directly to ACC or DONE. start_i is ignored in every other case.
- On an accepted start: all accumulators are cleared, err_o is cleared, and the remaining-beat counter is loaded with len_i.
- in_ready_o = (state == ACC). A beat transfers when in_valid_i && in_ready_o; each transfer decrements the counter.

## Timing
- Reset values: in_ready_o=0, out_valid_o=0, out_acc_o=0, busy_o=0, err_o=0. The FSM resets to IDLE and the pipeline valid bit to 0.
- Reset mid-run aborts the run immediately; all state is lost.
- Stage 1 registers coef, sel and a valid bit on each transfer. Stage 2 updates the accumulators from the stage 1 registers.
- Latency: last beat accepted at edge t → accumulators final at edge t+1 → out_valid_o high after edge t+1.
- out_valid_o is high exactly in DONE. out_acc_o and out_valid_o stay stable until out_ready_i.
- Back-to-back beats are accepted every cycle in ACC; gaps in in_valid_i are allowed.
- err_o is updated in stage 2 and remains readable through DONE.

## Structure
- Package mul_ternary_pkg holds:
  - selector constants SEL_HOLD, SEL_ADD, SEL_RSVD, SEL_SUB;
  - state enum IDLE/ACC/DRAIN/DONE.
- Sub-module mau_lane, instantiated LANES times in a generate loop: the combinational mod-q add/sub plus the lane accumulator register with a clear input.
- Top level holds the FSM, the beat counter, the stage 1 registers and the err_o OR-reduce.

## Test plan
All scenarios use Q=251, LANES=4.
- Reset: rst_n low mid-ACC → all outputs 0 immediately; after release, in_ready_o=0 and state IDLE.
- Add/sub wrap: len=3; lane0 coefs 200,100,10 with sel 01,01,11 → lane0=39; other lanes sel 00 → 0. out_valid_o asserts 2 edges after the last beat.
- Underflow: len=1; lane1 coef 5, sel 11 → lane1=246. Lane2 with len=2, coefs 250,250, sel 01 → 249.
- Backpressure: out_ready_i low for 5 cycles in DONE → out_acc_o held stable, in_ready_o=0, start_i ignored. Start asserted together with the handshake → new run begins and accumulators read 0.
- len=0: start with len_i=0 → out_valid_o the next cycle with an all-zero vector; in_ready_o never asserts.
- Reserved selector: one beat with sel 10 on lane3 → err_o=1 and lane3 unchanged; the next accepted start clears err_o.

Source files
------------

// File: rtl/mul_ternary_pkg.sv
// Shared selector encodings and FSM state type for the ternary multiply-accumulate engine.
package mul_ternary_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_ADD  = 2'b01;
    localparam logic [1:0] SEL_RSVD = 2'b10;
    localparam logic [1:0] SEL_SUB  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACC   = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/mau_lane.sv
// One accumulator lane: mod-q add/subtract of the stage-1 coefficient into a private register.
module mau_lane
    import mul_ternary_pkg::*;
#(
    parameter int PARAM_LOG_Q = 8,
    parameter int PARAM_Q     = 251
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   vld_p1,
    input  logic [1:0]             sel_p1,
    input  logic [PARAM_LOG_Q-1:0] coef_p1,
    output logic [PARAM_LOG_Q-1:0] acc_o
);

    localparam logic [PARAM_LOG_Q:0] Q_EXT = (PARAM_LOG_Q+1)'(PARAM_Q);

    logic [PARAM_LOG_Q-1:0] acc_p2;
    logic [PARAM_LOG_Q-1:0] acc_nxt;

    // Inputs are already < 2q, so one conditional subtract restores the range.
    function automatic logic [PARAM_LOG_Q-1:0] mod_reduce(input logic [PARAM_LOG_Q:0] v);
        if (v >= Q_EXT)
            return PARAM_LOG_Q'(v - Q_EXT);
        return v[PARAM_LOG_Q-1:0];
    endfunction

    always_comb begin
        acc_nxt = acc_p2;
        unique case (sel_p1)
            SEL_ADD: acc_nxt = mod_reduce({1'b0, acc_p2} + {1'b0, coef_p1});
            SEL_SUB: acc_nxt = mod_reduce({1'b0, acc_p2} + Q_EXT - {1'b0, coef_p1});
            default: acc_nxt = acc_p2;
        endcase
    end

    // Stage 2: accumulator update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_p2 <= '0;
        else if (clr)
            acc_p2 <= '0;
        else if (vld_p1)
            acc_p2 <= acc_nxt;
    end

    assign acc_o = acc_p2;

endmodule

// File: rtl/mau_accumulator.sv
// Multi-lane pipelined ternary MAC: FSM, beat counter, stage-1 registers and lane array.
module mau_accumulator
    import mul_ternary_pkg::*;
#(
    parameter int PARAM_LOG_Q = 8,
    parameter int PARAM_Q     = 251,
    parameter int LANES       = 4,
    parameter int LEN_W       = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic [LEN_W-1:0]             len_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [LANES*PARAM_LOG_Q-1:0] in_coef_i,
    input  logic [2*LANES-1:0]           in_sel_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [LANES*PARAM_LOG_Q-1:0] out_acc_o,
    output logic                         busy_o,
    output logic                         err_o
);

    state_t                       state, state_nxt;
    logic [LEN_W-1:0]             cnt;
    logic                         start_acc;
    logic                         xfer;
    logic                         last_beat;

    logic                         vld_p1;
    logic [LANES*PARAM_LOG_Q-1:0] coef_p1;
    logic [2*LANES-1:0]           sel_p1;
    logic [LANES-1:0]             rsvd_p1;
    logic                         err_p2;

    // A new run may begin from IDLE, or from DONE while the result is being taken.
    assign start_acc = start_i && ((state == IDLE) || ((state == DONE) && out_ready_i));
    assign xfer      = in_valid_i && (state == ACC);
    assign last_beat = xfer && (cnt == LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_acc) state_nxt = (len_i != '0) ? ACC : DONE;
            ACC:     if (last_beat) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE: begin
                if (start_acc)
                    state_nxt = (len_i != '0) ? ACC : DONE;
                else if (out_ready_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state == ACC);
        out_valid_o = (state == DONE);
        busy_o      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (start_acc)
            cnt <= len_i;
        else if (xfer)
            cnt <= cnt - LEN_W'(1);
    end

    // Stage 1: capture the accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= xfer;
    end

    always_ff @(posedge clk) begin
        if (xfer) begin
            coef_p1 <= in_coef_i;
            sel_p1  <= in_sel_i;
        end
    end

    // Stage 2: lane accumulators and sticky reserved-selector flag
    genvar l;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            assign rsvd_p1[l] = (sel_p1[2*l +: 2] == SEL_RSVD);

            mau_lane #(
                .PARAM_LOG_Q (PARAM_LOG_Q),
                .PARAM_Q     (PARAM_Q)
            ) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (start_acc),
                .vld_p1  (vld_p1),
                .sel_p1  (sel_p1[2*l +: 2]),
                .coef_p1 (coef_p1[l*PARAM_LOG_Q +: PARAM_LOG_Q]),
                .acc_o   (out_acc_o[l*PARAM_LOG_Q +: PARAM_LOG_Q])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_p2 <= 1'b0;
        else if (start_acc)
            err_p2 <= 1'b0;
        else if (vld_p1 && (|rsvd_p1))
            err_p2 <= 1'b1;
    end

    assign err_o = err_p2;

endmodule

// File: tb/tb_mau_accumulator.sv
// Randomised and directed bench for mau_accumulator against a plain-arithmetic mod-q model.
module tb_mau_accumulator;

    localparam int LQ = 8;
    localparam int Q  = 251;
    localparam int L  = 4;
    localparam int LW = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_i = 1'b0;
    logic [LW-1:0]   len_i = '0;
    logic            in_valid_i = 1'b0;
    logic            in_ready_o;
    logic [L*LQ-1:0] in_coef_i = '0;
    logic [2*L-1:0]  in_sel_i = '0;
    logic            out_valid_o;
    logic            out_ready_i = 1'b0;
    logic [L*LQ-1:0] out_acc_o;
    logic            busy_o;
    logic            err_o;

    mau_accumulator #(
        .PARAM_LOG_Q (LQ),
        .PARAM_Q     (Q),
        .LANES       (L),
        .LEN_W       (LW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .len_i       (len_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_coef_i   (in_coef_i),
        .in_sel_i    (in_sel_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_acc_o   (out_acc_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int bcoef[64][L];
    int bsel[64][L];
    int exp_acc[L];
    bit exp_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_beats();
        for (int i = 0; i < 64; i++)
            for (int l = 0; l < L; l++) begin
                bcoef[i][l] = $urandom_range(0, Q-1);
                bsel[i][l]  = 0;
            end
    endtask

    // Reference: each lane is an integer mod Q, updated by plain arithmetic.
    task automatic model_beat(input int i);
        for (int l = 0; l < L; l++) begin
            case (bsel[i][l])
                1: exp_acc[l] = (exp_acc[l] + bcoef[i][l]) % Q;
                3: exp_acc[l] = (exp_acc[l] - bcoef[i][l] + Q) % Q;
                2: exp_err = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic check_lanes(input string tag);
        for (int l = 0; l < L; l++)
            chk($sformatf("%s_lane%0d", tag, l), 64'(out_acc_o[l*LQ +: LQ]), 64'(exp_acc[l]));
    endtask

    task automatic model_clear();
        for (int l = 0; l < L; l++) exp_acc[l] = 0;
        exp_err = 1'b0;
    endtask

    task automatic start_run(input int len);
        start_i = 1'b1;
        len_i   = LW'(len);
        tick();
        start_i = 1'b0;
        model_clear();
        chk("start_ready", 64'(in_ready_o), 64'(len != 0));
        chk("start_ovld", 64'(out_valid_o), 64'(len == 0));
        chk("start_busy", 64'(busy_o), 1);
        chk("start_err", 64'(err_o), 0);
        check_lanes("start_clr");
    endtask

    task automatic feed(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 1)) begin
                    in_valid_i = 1'b0;
                    in_sel_i   = {L{2'b10}};
                    in_coef_i  = L*LQ'($urandom);
                    tick();
                end
            end
            for (int l = 0; l < L; l++) begin
                in_coef_i[l*LQ +: LQ] = LQ'(bcoef[i][l]);
                in_sel_i[2*l +: 2]    = 2'(bsel[i][l]);
            end
            in_valid_i = 1'b1;
            model_beat(i);
            tick();
        end
        in_valid_i = 1'b0;
    endtask

    task automatic finish_run();
        chk("drain_ovld", 64'(out_valid_o), 0);
        chk("drain_ready", 64'(in_ready_o), 0);
        tick();
        chk("done_ovld", 64'(out_valid_o), 1);
        chk("done_busy", 64'(busy_o), 1);
        chk("done_err", 64'(err_o), 64'(exp_err));
        check_lanes("done");
    endtask

    task automatic release_out(input int stall);
        out_ready_i = 1'b0;
        repeat (stall) begin
            start_i = 1'b1;
            len_i   = LW'(3);
            tick();
            chk("stall_ovld", 64'(out_valid_o), 1);
            chk("stall_ready", 64'(in_ready_o), 0);
            check_lanes("stall");
        end
        start_i     = 1'b0;
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("rel_ovld", 64'(out_valid_o), 0);
        chk("rel_busy", 64'(busy_o), 0);
    endtask

    initial begin
        model_clear();
        repeat (2) tick();
        chk("rst_ovld", 64'(out_valid_o), 0);
        chk("rst_ready", 64'(in_ready_o), 0);
        chk("rst_acc", 64'(out_acc_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_err", 64'(err_o), 0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of an accumulation
        clear_beats();
        for (int i = 0; i < 2; i++) for (int l = 0; l < L; l++) bsel[i][l] = 1;
        start_run(5);
        feed(2, 1'b0);
        tick();
        rst_n = 1'b0;
        #2;
        chk("mrst_acc", 64'(out_acc_o), 0);
        chk("mrst_ready", 64'(in_ready_o), 0);
        chk("mrst_busy", 64'(busy_o), 0);
        chk("mrst_ovld", 64'(out_valid_o), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 64'(in_ready_o), 0);
        chk("post_rst_busy", 64'(busy_o), 0);

        // Add/sub with wrap on lane 0
        clear_beats();
        bcoef[0][0] = 200; bsel[0][0] = 1;
        bcoef[1][0] = 100; bsel[1][0] = 1;
        bcoef[2][0] = 10;  bsel[2][0] = 3;
        start_run(3);
        feed(3, 1'b0);
        finish_run();
        chk("wrap_lane0", 64'(out_acc_o[7:0]), 39);
        chk("wrap_lane1", 64'(out_acc_o[15:8]), 0);
        release_out(0);

        // Subtract underflow on lane 1
        clear_beats();
        bcoef[0][1] = 5; bsel[0][1] = 3;
        start_run(1);
        feed(1, 1'b0);
        finish_run();
        chk("uflow_lane1", 64'(out_acc_o[15:8]), 246);
        release_out(0);

        // Add at the top of the range on lane 2
        clear_beats();
        bcoef[0][2] = 250; bsel[0][2] = 1;
        bcoef[1][2] = 250; bsel[1][2] = 1;
        start_run(2);
        feed(2, 1'b1);
        finish_run();
        chk("top_lane2", 64'(out_acc_o[23:16]), 249);

        // Backpressure, then a start that rides on the output handshake
        release_out(0 + 5 - 5);
        clear_beats();
        for (int l = 0; l < L; l++) begin bsel[0][l] = 1; bsel[1][l] = 3; end
        start_run(2);
        feed(2, 1'b0);
        finish_run();
        out_ready_i = 1'b0;
        repeat (5) begin
            start_i = 1'b1;
            len_i   = LW'(2);
            tick();
            chk("bp_ovld", 64'(out_valid_o), 1);
            chk("bp_ready", 64'(in_ready_o), 0);
            check_lanes("bp");
        end
        out_ready_i = 1'b1;
        start_i     = 1'b1;
        len_i       = LW'(2);
        tick();
        out_ready_i = 1'b0;
        start_i     = 1'b0;
        model_clear();
        chk("hs_start_ovld", 64'(out_valid_o), 0);
        chk("hs_start_ready", 64'(in_ready_o), 1);
        chk("hs_start_acc", 64'(out_acc_o), 0);
        clear_beats();
        for (int l = 0; l < L; l++) bsel[0][l] = 1;
        feed(2, 1'b0);
        finish_run();
        release_out(0);

        // Zero-length run
        start_run(0);
        chk("len0_acc", 64'(out_acc_o), 0);
        release_out(1);

        // Reserved selector on lane 3
        clear_beats();
        bcoef[0][3] = 7; bsel[0][3] = 1;
        bcoef[1][3] = 9; bsel[1][3] = 2;
        start_run(2);
        feed(2, 1'b0);
        finish_run();
        chk("rsvd_err", 64'(err_o), 1);
        chk("rsvd_lane3", 64'(out_acc_o[31:24]), 7);
        release_out(0);
        chk("rsvd_err_kept_idle", 64'(err_o), 1);

        // Randomised runs
        for (int r = 0; r < 25; r++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++)
                for (int l = 0; l < L; l++) begin
                    bcoef[i][l] = $urandom_range(0, Q-1);
                    bsel[i][l]  = ($urandom_range(0, 19) == 0) ? 2 :
                                  (($urandom_range(0, 2) == 0) ? 0 :
                                  (($urandom_range(0, 1) == 0) ? 1 : 3));
                end
            start_run(len);
            feed(len, 1'b1);
            finish_run();
            release_out($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
